// File: rtl/ex_mem_wb_pipeline.sv
// ---------------------------------------------------------------------------
// ex_mem_wb_pipeline
//
// EX/MEM and MEM/WB pipeline register bank for the 5-stage MIPS core.
// The EX/MEM register captures the EX-stage result and control. A pending
// load/store drives a request/ready handshake to data memory. While memory
// has not answered, the front of the pipe is stalled and bubbles are fed
// into MEM/WB. The EX_MEM_* / MEM_WB_* outputs feed the forwarding unit.
//
// Optional feature: define MEM_TIMEOUT_EN to abort an access after
// TIMEOUT_CYCLES wait cycles. An aborted load writes 0, and o_mem_error
// becomes sticky until reset. Without the macro, o_mem_error is always 0.
//
// Ports:
//   clk, reset (async, active-high)
//   in_ID_EX_*            EX-stage instruction, control and operands
//   in_flush              turn the instruction being captured into a bubble
//   in_mem_ready/rdata    data-memory completion and load data
//   o_mem_req/we/addr/wdata  data-memory access
//   o_stall_upstream      PC, IF/ID and ID/EX must hold
//   o_EX_MEM_*, o_MEM_WB_*   forwarding/write-back view of the pipe regs
//   o_mem_error           sticky timeout flag
// ---------------------------------------------------------------------------
module ex_mem_wb_pipeline #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_ID_EX_valid,
    input  logic        in_ID_EX_RegWrite,
    input  logic        in_ID_EX_MemRead,
    input  logic        in_ID_EX_MemWrite,
    input  logic        in_ID_EX_MemtoReg,
    input  logic [4:0]  in_ID_EX_Rd_address_5,
    input  logic [4:0]  in_ID_EX_Rs_address_5,
    input  logic [31:0] in_ALU_result_32,
    input  logic [31:0] in_ID_EX_Rt_data_32,
    input  logic        in_flush,
    input  logic        in_mem_ready,
    input  logic [31:0] in_mem_rdata_32,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr_32,
    output logic [31:0] o_mem_wdata_32,
    output logic        o_stall_upstream,
    output logic        o_EX_MEM_RegWrite,
    output logic [4:0]  o_EX_MEM_Rd_address_5,
    output logic [4:0]  o_EX_MEM_Rs_address_5,
    output logic [31:0] o_EX_MEM_ALU_result_32,
    output logic        o_MEM_WB_RegWrite,
    output logic [4:0]  o_MEM_WB_Rd_address_5,
    output logic [31:0] o_MEM_WB_write_data_32,
    output logic        o_mem_error
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } mem_state_t;

    mem_state_t state, state_next;

    logic        exm_valid;
    logic        exm_regwrite;
    logic        exm_memread;
    logic        exm_memwrite;
    logic        exm_memtoreg;
    logic [4:0]  exm_rd;
    logic [4:0]  exm_rs;
    logic [31:0] exm_alu;
    logic [31:0] exm_wdata;

    logic        mwb_regwrite;
    logic [4:0]  mwb_rd;
    logic [31:0] mwb_data;

    logic        pending;
    logic        timeout;
    logic        stall;
    logic        capture_bubble;
    logic [31:0] load_data;

    assign pending = exm_valid & (exm_memread | exm_memwrite);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] wait_cnt;
    logic             mem_error;

    // Abort on the last allowed wait cycle if memory still has not answered:
    // one stall cycle is spent in IDLE, TIMEOUT_CYCLES-1 more in WAIT.
    assign timeout = (state == S_WAIT) && !in_mem_ready &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt  <= '0;
            mem_error <= 1'b0;
        end else begin
            if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (timeout) begin
                mem_error <= 1'b1;
            end
        end
    end

    assign o_mem_error = mem_error;
`else
    // Accesses never time out; TIMEOUT_CYCLES has no effect in this build.
    assign timeout     = (TIMEOUT_CYCLES < 0);
    assign o_mem_error = 1'b0;
`endif

    // Combinational from in_mem_ready so a zero-wait access never stalls.
    assign stall = pending & ~in_mem_ready & ~timeout;

    // ---- MEM FSM ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (pending && !in_mem_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (in_mem_ready || timeout) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ---- EX/MEM register ----
    assign capture_bubble = in_flush | ~in_ID_EX_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exm_valid    <= 1'b0;
            exm_regwrite <= 1'b0;
            exm_memread  <= 1'b0;
            exm_memwrite <= 1'b0;
            exm_memtoreg <= 1'b0;
            exm_rd       <= '0;
            exm_rs       <= '0;
            exm_alu      <= '0;
            exm_wdata    <= '0;
        end else if (!stall) begin
            if (capture_bubble) begin
                exm_valid    <= 1'b0;
                exm_regwrite <= 1'b0;
                exm_memread  <= 1'b0;
                exm_memwrite <= 1'b0;
                exm_memtoreg <= 1'b0;
                exm_rd       <= '0;
                exm_rs       <= '0;
                exm_alu      <= '0;
                exm_wdata    <= '0;
            end else begin
                exm_valid    <= 1'b1;
                exm_regwrite <= in_ID_EX_RegWrite;
                exm_memread  <= in_ID_EX_MemRead;
                exm_memwrite <= in_ID_EX_MemWrite;
                exm_memtoreg <= in_ID_EX_MemtoReg;
                exm_rd       <= in_ID_EX_Rd_address_5;
                exm_rs       <= in_ID_EX_Rs_address_5;
                exm_alu      <= in_ALU_result_32;
                exm_wdata    <= in_ID_EX_Rt_data_32;
            end
        end
    end

    // ---- MEM/WB register ----
    // An aborted load has no valid read data and writes 0 instead.
    assign load_data = timeout ? 32'd0 : in_mem_rdata_32;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mwb_regwrite <= 1'b0;
            mwb_rd       <= '0;
            mwb_data     <= '0;
        end else if (stall) begin
            mwb_regwrite <= 1'b0;
        end else begin
            // Stores never write the register file.
            mwb_regwrite <= exm_valid & exm_regwrite & ~exm_memwrite;
            mwb_rd       <= exm_rd;
            mwb_data     <= exm_memtoreg ? load_data : exm_alu;
        end
    end

    assign o_mem_req              = pending;
    assign o_mem_we               = pending & exm_memwrite;
    assign o_mem_addr_32          = exm_alu;
    assign o_mem_wdata_32         = exm_wdata;
    assign o_stall_upstream       = stall;
    assign o_EX_MEM_RegWrite      = exm_valid & exm_regwrite;
    assign o_EX_MEM_Rd_address_5  = exm_rd;
    assign o_EX_MEM_Rs_address_5  = exm_rs;
    assign o_EX_MEM_ALU_result_32 = exm_alu;
    assign o_MEM_WB_RegWrite      = mwb_regwrite;
    assign o_MEM_WB_Rd_address_5  = mwb_rd;
    assign o_MEM_WB_write_data_32 = mwb_data;

endmodule

// File: tb/tb_ex_mem_wb_pipeline.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_wb_pipeline
//
// Directed bench for ex_mem_wb_pipeline: ALU op, zero-wait load, waited
// load with flush during stall, store, flush, reset during WAIT and (with
// MEM_TIMEOUT_EN) the timeout abort. Inputs change 1 ns after the rising
// edge; outputs are sampled before the next rising edge.
// ---------------------------------------------------------------------------
module tb_ex_mem_wb_pipeline;

    logic        clk;
    logic        reset;
    logic        in_ID_EX_valid;
    logic        in_ID_EX_RegWrite;
    logic        in_ID_EX_MemRead;
    logic        in_ID_EX_MemWrite;
    logic        in_ID_EX_MemtoReg;
    logic [4:0]  in_ID_EX_Rd_address_5;
    logic [4:0]  in_ID_EX_Rs_address_5;
    logic [31:0] in_ALU_result_32;
    logic [31:0] in_ID_EX_Rt_data_32;
    logic        in_flush;
    logic        in_mem_ready;
    logic [31:0] in_mem_rdata_32;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr_32;
    logic [31:0] o_mem_wdata_32;
    logic        o_stall_upstream;
    logic        o_EX_MEM_RegWrite;
    logic [4:0]  o_EX_MEM_Rd_address_5;
    logic [4:0]  o_EX_MEM_Rs_address_5;
    logic [31:0] o_EX_MEM_ALU_result_32;
    logic        o_MEM_WB_RegWrite;
    logic [4:0]  o_MEM_WB_Rd_address_5;
    logic [31:0] o_MEM_WB_write_data_32;
    logic        o_mem_error;

    int checks;
    int failures;

    ex_mem_wb_pipeline #(.TIMEOUT_CYCLES(4)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .in_ID_EX_valid         (in_ID_EX_valid),
        .in_ID_EX_RegWrite      (in_ID_EX_RegWrite),
        .in_ID_EX_MemRead       (in_ID_EX_MemRead),
        .in_ID_EX_MemWrite      (in_ID_EX_MemWrite),
        .in_ID_EX_MemtoReg      (in_ID_EX_MemtoReg),
        .in_ID_EX_Rd_address_5  (in_ID_EX_Rd_address_5),
        .in_ID_EX_Rs_address_5  (in_ID_EX_Rs_address_5),
        .in_ALU_result_32       (in_ALU_result_32),
        .in_ID_EX_Rt_data_32    (in_ID_EX_Rt_data_32),
        .in_flush               (in_flush),
        .in_mem_ready           (in_mem_ready),
        .in_mem_rdata_32        (in_mem_rdata_32),
        .o_mem_req              (o_mem_req),
        .o_mem_we               (o_mem_we),
        .o_mem_addr_32          (o_mem_addr_32),
        .o_mem_wdata_32         (o_mem_wdata_32),
        .o_stall_upstream       (o_stall_upstream),
        .o_EX_MEM_RegWrite      (o_EX_MEM_RegWrite),
        .o_EX_MEM_Rd_address_5  (o_EX_MEM_Rd_address_5),
        .o_EX_MEM_Rs_address_5  (o_EX_MEM_Rs_address_5),
        .o_EX_MEM_ALU_result_32 (o_EX_MEM_ALU_result_32),
        .o_MEM_WB_RegWrite      (o_MEM_WB_RegWrite),
        .o_MEM_WB_Rd_address_5  (o_MEM_WB_Rd_address_5),
        .o_MEM_WB_write_data_32 (o_MEM_WB_write_data_32),
        .o_mem_error            (o_mem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Advance one edge; inputs may be changed right after return.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_ID_EX_valid        = 1'b0;
        in_ID_EX_RegWrite     = 1'b0;
        in_ID_EX_MemRead      = 1'b0;
        in_ID_EX_MemWrite     = 1'b0;
        in_ID_EX_MemtoReg     = 1'b0;
        in_ID_EX_Rd_address_5 = 5'd0;
        in_ID_EX_Rs_address_5 = 5'd0;
        in_ALU_result_32      = 32'd0;
        in_ID_EX_Rt_data_32   = 32'd0;
        in_flush              = 1'b0;
    endtask

    task automatic set_alu(input logic [4:0] rd, input logic [4:0] rs,
                           input logic [31:0] res);
        idle_inputs();
        in_ID_EX_valid        = 1'b1;
        in_ID_EX_RegWrite     = 1'b1;
        in_ID_EX_Rd_address_5 = rd;
        in_ID_EX_Rs_address_5 = rs;
        in_ALU_result_32      = res;
    endtask

    task automatic set_load(input logic [4:0] rd, input logic [31:0] addr);
        idle_inputs();
        in_ID_EX_valid        = 1'b1;
        in_ID_EX_RegWrite     = 1'b1;
        in_ID_EX_MemRead      = 1'b1;
        in_ID_EX_MemtoReg     = 1'b1;
        in_ID_EX_Rd_address_5 = rd;
        in_ALU_result_32      = addr;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle_inputs();
        in_mem_ready    = 1'b0;
        in_mem_rdata_32 = 32'd0;
        reset           = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_req",      {31'd0, o_mem_req},          32'd0);
        check("rst_stall",    {31'd0, o_stall_upstream},   32'd0);
        check("rst_exm_rw",   {31'd0, o_EX_MEM_RegWrite},  32'd0);
        check("rst_mwb_rw",   {31'd0, o_MEM_WB_RegWrite},  32'd0);
        check("rst_mwb_data", o_MEM_WB_write_data_32,      32'd0);
        check("rst_err",      {31'd0, o_mem_error},        32'd0);
        reset = 1'b0;

        // ALU op Rd=5, result 0xAA
        set_alu(5'd5, 5'd3, 32'h0000_00AA);
        #1;
        check("alu_stall0", {31'd0, o_stall_upstream}, 32'd0);
        tick();
        idle_inputs();
        check("alu_exm_rd",  {27'd0, o_EX_MEM_Rd_address_5}, 32'd5);
        check("alu_exm_rs",  {27'd0, o_EX_MEM_Rs_address_5}, 32'd3);
        check("alu_exm_rw",  {31'd0, o_EX_MEM_RegWrite},     32'd1);
        check("alu_exm_res", o_EX_MEM_ALU_result_32,         32'h0000_00AA);
        check("alu_req",     {31'd0, o_mem_req},             32'd0);
        tick();
        check("alu_mwb_data", o_MEM_WB_write_data_32,        32'h0000_00AA);
        check("alu_mwb_rw",   {31'd0, o_MEM_WB_RegWrite},    32'd1);
        check("alu_mwb_rd",   {27'd0, o_MEM_WB_Rd_address_5}, 32'd5);

        // Zero-wait load, address 0x40, data 0x1234
        set_load(5'd7, 32'h0000_0040);
        tick();
        idle_inputs();
        in_mem_ready    = 1'b1;
        in_mem_rdata_32 = 32'h0000_1234;
        #1;
        check("ld0_req",   {31'd0, o_mem_req},        32'd1);
        check("ld0_we",    {31'd0, o_mem_we},         32'd0);
        check("ld0_addr",  o_mem_addr_32,             32'h0000_0040);
        check("ld0_stall", {31'd0, o_stall_upstream}, 32'd0);
        tick();
        in_mem_ready = 1'b0;
        check("ld0_mwb_data", o_MEM_WB_write_data_32,        32'h0000_1234);
        check("ld0_mwb_rw",   {31'd0, o_MEM_WB_RegWrite},    32'd1);
        check("ld0_mwb_rd",   {27'd0, o_MEM_WB_Rd_address_5}, 32'd7);

        // Load with 3 wait cycles; next instruction (ALU Rd=10) waits upstream,
        // and a flush during the last stall cycle must be ignored.
        set_load(5'd9, 32'h0000_0044);
        tick();
        set_alu(5'd10, 5'd2, 32'h0000_0055);
        in_mem_rdata_32 = 32'h0000_BEEF;
        for (int i = 0; i < 3; i++) begin
            in_flush = (i == 2);
            #1;
            check("ld3_stall", {31'd0, o_stall_upstream}, 32'd1);
            tick();
            check("ld3_bubble", {31'd0, o_MEM_WB_RegWrite},     32'd0);
            check("ld3_exm_rd", {27'd0, o_EX_MEM_Rd_address_5}, 32'd9);
            check("ld3_addr",   o_mem_addr_32,                  32'h0000_0044);
        end
        in_flush        = 1'b0;
        in_mem_ready    = 1'b1;
        in_mem_rdata_32 = 32'h0000_CAFE;
        #1;
        check("ld3_stall_end", {31'd0, o_stall_upstream}, 32'd0);
        tick();
        in_mem_ready = 1'b0;
        idle_inputs();
        check("ld3_mwb_data", o_MEM_WB_write_data_32,        32'h0000_CAFE);
        check("ld3_mwb_rw",   {31'd0, o_MEM_WB_RegWrite},    32'd1);
        check("ld3_mwb_rd",   {27'd0, o_MEM_WB_Rd_address_5}, 32'd9);
        check("ld3_next_rd",  {27'd0, o_EX_MEM_Rd_address_5}, 32'd10);
        tick();
        check("ld3_next_mwb", o_MEM_WB_write_data_32, 32'h0000_0055);

        // Store to 0x80 of 0xDEADBEEF with RegWrite asserted on input
        idle_inputs();
        in_ID_EX_valid        = 1'b1;
        in_ID_EX_RegWrite     = 1'b1;
        in_ID_EX_MemWrite     = 1'b1;
        in_ID_EX_Rd_address_5 = 5'd11;
        in_ALU_result_32      = 32'h0000_0080;
        in_ID_EX_Rt_data_32   = 32'hDEAD_BEEF;
        tick();
        idle_inputs();
        in_mem_ready = 1'b1;
        #1;
        check("st_req",   {31'd0, o_mem_req},        32'd1);
        check("st_we",    {31'd0, o_mem_we},         32'd1);
        check("st_addr",  o_mem_addr_32,             32'h0000_0080);
        check("st_wdata", o_mem_wdata_32,            32'hDEAD_BEEF);
        check("st_stall", {31'd0, o_stall_upstream}, 32'd0);
        tick();
        in_mem_ready = 1'b0;
        check("st_mwb_rw", {31'd0, o_MEM_WB_RegWrite}, 32'd0);

        // Flush an ALU op with RegWrite=1
        set_alu(5'd12, 5'd4, 32'h0000_0077);
        in_flush = 1'b1;
        tick();
        idle_inputs();
        check("fl_exm_rw", {31'd0, o_EX_MEM_RegWrite},     32'd0);
        check("fl_exm_rd", {27'd0, o_EX_MEM_Rd_address_5}, 32'd0);

        // Reset asserted during WAIT
        set_load(5'd13, 32'h0000_0090);
        tick();
        idle_inputs();
        tick();
        check("rw_stall_pre", {31'd0, o_stall_upstream}, 32'd1);
        check("rw_req_pre",   {31'd0, o_mem_req},        32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rw_req",    {31'd0, o_mem_req},          32'd0);
        check("rw_stall",  {31'd0, o_stall_upstream},   32'd0);
        check("rw_addr",   o_mem_addr_32,               32'd0);
        check("rw_exm_rw", {31'd0, o_EX_MEM_RegWrite},  32'd0);
        check("rw_mwb_rw", {31'd0, o_MEM_WB_RegWrite},  32'd0);
        tick();
        reset = 1'b0;
        // After reset a zero-wait load must go straight through.
        set_load(5'd15, 32'h0000_0048);
        tick();
        idle_inputs();
        in_mem_ready    = 1'b1;
        in_mem_rdata_32 = 32'h0000_5A5A;
        #1;
        check("rw_after_stall", {31'd0, o_stall_upstream}, 32'd0);
        tick();
        in_mem_ready = 1'b0;
        check("rw_after_data", o_MEM_WB_write_data_32, 32'h0000_5A5A);

`ifdef MEM_TIMEOUT_EN
        // Timeout: ready never comes, TIMEOUT_CYCLES=4
        set_load(5'd14, 32'h0000_00A0);
        in_mem_rdata_32 = 32'hFFFF_FFFF;
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            #1;
            check("to_stall", {31'd0, o_stall_upstream}, 32'd1);
            tick();
        end
        #1;
        check("to_stall_end", {31'd0, o_stall_upstream}, 32'd0);
        check("to_err_pre",   {31'd0, o_mem_error},      32'd0);
        tick();
        check("to_err",      {31'd0, o_mem_error},          32'd1);
        check("to_mwb_rw",   {31'd0, o_MEM_WB_RegWrite},    32'd1);
        check("to_mwb_data", o_MEM_WB_write_data_32,        32'd0);
        check("to_mwb_rd",   {27'd0, o_MEM_WB_Rd_address_5}, 32'd14);
        tick();
        check("to_err_sticky", {31'd0, o_mem_error}, 32'd1);
`else
        check("no_err", {31'd0, o_mem_error}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
